// File: rtl/redma_rd_ctrl_pkg.sv
// Shared constants, types and burst-length arithmetic for the DMA read sequencer.
// Bursts are AXI4 INCR, capped at 256 beats and never crossing a 4 KB page.
package redma_rd_ctrl_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam int         AXI_4K_BYTES   = 4096;
   localparam int         AXI_MAX_BEATS  = 256;

   localparam int CMD_ADDR_W = 64;
   localparam int CMD_LEN_W  = 32;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_LEN_W-1:0]  nbeats;
   } rd_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DRAIN = 2'd3
   } rd_state_e;

   // rem_cap is the remaining count already clamped to AXI_MAX_BEATS, so the
   // result is min(remaining, 256, beats left in the current 4 KB page).
   function automatic logic [8:0] calc_blen(input logic [11:0] addr_lo,
                                            input logic [8:0]  rem_cap,
                                            input logic [2:0]  sz);
      logic [12:0] beats_4k;
      beats_4k = (13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> sz;
      if ({4'd0, rem_cap} <= beats_4k) begin
         return rem_cap;
      end
      return beats_4k[8:0];
   endfunction

endpackage

// File: rtl/redma_burst_split.sv
// Combinational burst sizing: picks the next burst length from the current
// page offset and the beats still owed to the command.
module redma_burst_split
   import redma_rd_ctrl_pkg::*;
#(
   parameter int LEN_WIDTH = 32,
   parameter int SZ        = 6
) (
   input  logic [11:0]          addr_lo_i,
   input  logic [LEN_WIDTH-1:0] remaining_i,
   output logic [8:0]           blen_o,
   output logic [7:0]           arlen_o
);

   logic [8:0] rem_cap;

   always_comb begin
      if (remaining_i >= LEN_WIDTH'(AXI_MAX_BEATS)) begin
         rem_cap = 9'(AXI_MAX_BEATS);
      end else begin
         rem_cap = remaining_i[8:0];
      end
   end

   assign blen_o  = calc_blen(addr_lo_i, rem_cap, 3'(SZ));
   assign arlen_o = 8'(blen_o - 9'd1);

endmodule

// File: rtl/redma_rd_ctrl.sv
// DMA read-side sequencer: splits queued read commands into AXI4 INCR bursts
// with bounded outstanding count, and streams R data straight into the sink FIFO.
module redma_rd_ctrl
   import redma_rd_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 512,
   parameter int LEN_WIDTH       = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_empty_i,
   output logic                            cmd_read_o,
   input  logic [ADDR_WIDTH+LEN_WIDTH-1:0] cmd_data_i,
   output logic                            arvalid_o,
   input  logic                            arready_i,
   output logic [ADDR_WIDTH-1:0]           araddr_o,
   output logic [7:0]                      arlen_o,
   output logic [2:0]                      arsize_o,
   output logic [1:0]                      arburst_o,
   input  logic                            rvalid_i,
   output logic                            rready_o,
   input  logic [DATA_WIDTH-1:0]           rdata_i,
   input  logic                            rlast_i,
   input  logic                            dout_full_i,
   output logic                            dout_write_o,
   output logic [DATA_WIDTH-1:0]           dout_data_o,
   output logic                            busy_o,
   output logic                            done_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SZ    = $clog2(BYTES);
   localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OS_W-1:0] OS_MAX = OS_W'(MAX_OUTSTANDING);

   rd_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [8:0]            blen_q, blen_d;
   logic [7:0]            arlen_q, arlen_d;
   logic                  busy_q, busy_d;
   logic                  ar_hold_q, ar_hold_d;
   logic [OS_W-1:0]       os_q, os_d;

   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_nbeats;
   logic [8:0]            split_blen;
   logic [7:0]            split_arlen;
   logic                  ar_fire;
   logic                  rlast_fire;

   assign {cmd_addr, cmd_nbeats} = cmd_data_i;

   redma_burst_split #(
      .LEN_WIDTH (LEN_WIDTH),
      .SZ        (SZ)
   ) u_split (
      .addr_lo_i   (addr_q[11:0]),
      .remaining_i (remaining_q),
      .blen_o      (split_blen),
      .arlen_o     (split_arlen)
   );

   // Zero-latency R pass-through; full stalls the slave rather than dropping beats.
   assign rready_o     = !rst && !dout_full_i;
   assign dout_write_o = rvalid_i && rready_o;
   assign dout_data_o  = rdata_i;

   assign ar_fire    = arvalid_o && arready_i;
   assign rlast_fire = rvalid_i && rready_o && rlast_i;

   assign araddr_o  = araddr_q;
   assign arlen_o   = arlen_q;
   assign arsize_o  = 3'(SZ);
   assign arburst_o = AXI_BURST_INCR;
   assign busy_o    = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!cmd_empty_i) state_d = ST_CALC;
         ST_CALC:  state_d = (remaining_q == '0) ? ST_DRAIN : ST_ISSUE;
         ST_ISSUE: if (ar_fire) state_d = ST_CALC;
         ST_DRAIN: if (os_q == '0) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Once raised, arvalid is held by ar_hold_q even if the outstanding room closes.
   always_comb begin
      cmd_read_o = 1'b0;
      arvalid_o  = 1'b0;
      done_o     = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_IDLE:  cmd_read_o = !cmd_empty_i;
            ST_ISSUE: arvalid_o  = ar_hold_q || (os_q < OS_MAX);
            ST_DRAIN: done_o     = (os_q == '0);
            default:  ;
         endcase
      end
   end

   always_comb begin
      addr_d      = addr_q;
      araddr_d    = araddr_q;
      remaining_d = remaining_q;
      blen_d      = blen_q;
      arlen_d     = arlen_q;
      busy_d      = busy_q;
      ar_hold_d   = arvalid_o && !arready_i;
      os_d        = os_q;

      if (cmd_read_o) begin
         addr_d      = cmd_addr;
         remaining_d = cmd_nbeats;
         busy_d      = 1'b1;
      end
      if (state_q == ST_CALC && remaining_q != '0) begin
         araddr_d = addr_q;
         arlen_d  = split_arlen;
         blen_d   = split_blen;
      end
      if (ar_fire) begin
         addr_d      = addr_q + (ADDR_WIDTH'(blen_q) << SZ);
         remaining_d = remaining_q - LEN_WIDTH'(blen_q);
      end
      if (done_o) begin
         busy_d = 1'b0;
      end

      case ({ar_fire, rlast_fire && (os_q != '0)})
         2'b10:   os_d = os_q + 1'b1;
         2'b01:   os_d = os_q - 1'b1;
         default: os_d = os_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         araddr_q    <= '0;
         remaining_q <= '0;
         blen_q      <= '0;
         arlen_q     <= '0;
         busy_q      <= 1'b0;
         ar_hold_q   <= 1'b0;
         os_q        <= '0;
      end else begin
         addr_q      <= addr_d;
         araddr_q    <= araddr_d;
         remaining_q <= remaining_d;
         blen_q      <= blen_d;
         arlen_q     <= arlen_d;
         busy_q      <= busy_d;
         ar_hold_q   <= ar_hold_d;
         os_q        <= os_d;
      end
   end

   // A last beat with nothing outstanding means the slave returned an unrequested burst.
   assert property (@(posedge clk) disable iff (rst) !(rlast_fire && os_q == '0));

endmodule
